bat_motion_ctrl: RTL and testbench

BAT_MOTION_CTRL -- requirements
Module: bat_motion_ctrl

---
 rtl/bat_pkg.sv | 25 ++
 rtl/bat_speed_ramp.sv | 118 +++++++++++
 rtl/bat_motion_ctrl.sv | 121 ++++++++++++
 tb/tb_bat_motion_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bat_pkg
//  Description : Shared definitions for the bat motion controller: the speed
//                FSM state encoding, the default fixed-point fraction width
//                and the width of the speed datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package bat_pkg;

    // Default number of fraction bits in the fixed-point position.
    localparam int FRAC_BITS_DEF = 6;

    // Speed register width; wide enough for any practical MAX_SPEED + ACCEL.
    localparam int SPEED_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2,
        ST_BRAKE  = 2'd3
    } bat_state_t;

endpackage
`default_nettype wire

// File: rtl/bat_speed_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : bat_speed_ramp
//  Description : Per-frame speed FSM (IDLE/ACCEL/CRUISE/BRAKE) with the speed
//                and direction registers. The next speed/direction are also
//                exported combinationally so the parent can move the bat by
//                the new speed within the same frame.
//  Ports       : clk, resetN      - clock, asynchronous active-low reset
//                i_advance        - frame update enable (frame pulse, no hit)
//                i_clamp          - position clamped this frame: stop dead
//                i_right, i_left  - movement requests
//                o_speed, o_dir   - registered speed / direction (1 = right)
//                o_speed_nxt      - speed that will be loaded on this frame
//                o_dir_nxt        - direction that will be loaded this frame
//                o_state          - registered FSM state
//  Revision    : 1.0 - initial release
// ============================================================================
module bat_speed_ramp
    import bat_pkg::*;
#(
    parameter int MIN_SPEED = 64,
    parameter int MAX_SPEED = 256,
    parameter int ACCEL     = 32
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_advance,
    input  logic               i_clamp,
    input  logic               i_right,
    input  logic               i_left,
    output logic [SPEED_W-1:0] o_speed,
    output logic               o_dir,
    output logic [SPEED_W-1:0] o_speed_nxt,
    output logic               o_dir_nxt,
    output bat_state_t         o_state
);

    bat_state_t         r_state;
    bat_state_t         w_state_nxt;
    logic [SPEED_W-1:0] r_speed;
    logic [SPEED_W-1:0] w_speed_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic [SPEED_W:0]   w_up_sum;
    logic [SPEED_W-1:0] w_up_sat;
    logic [SPEED_W-1:0] w_down_sat;
    logic               w_key_held;

    // Only the key matching the current direction, alone, keeps us going.
    assign w_key_held = r_dir ? (i_right & ~i_left) : (i_left & ~i_right);

    assign w_up_sum   = {1'b0, r_speed} + (SPEED_W+1)'(ACCEL);
    assign w_up_sat   = (w_up_sum >= (SPEED_W+1)'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                              : w_up_sum[SPEED_W-1:0];
    assign w_down_sat = (r_speed > SPEED_W'(ACCEL)) ? (r_speed - SPEED_W'(ACCEL)) : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
            r_speed <= '0;
            r_dir   <= 1'b1;
        end else if (i_advance) begin
            r_dir <= w_dir_nxt;
            if (i_clamp) begin
                r_state <= ST_IDLE;
                r_speed <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_speed <= w_speed_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        w_dir_nxt   = r_dir;
        case (r_state)
            ST_IDLE: begin
                if (i_right ^ i_left) begin
                    w_dir_nxt   = i_right;
                    w_speed_nxt = SPEED_W'(MIN_SPEED);
                    w_state_nxt = ST_ACCEL;
                end else begin
                    w_speed_nxt = '0;
                end
            end
            ST_ACCEL, ST_CRUISE: begin
                if (w_key_held) begin
                    w_speed_nxt = w_up_sat;
                    w_state_nxt = (w_up_sat == SPEED_W'(MAX_SPEED)) ? ST_CRUISE : ST_ACCEL;
                end else begin
                    // Braking starts in the release frame itself.
                    w_speed_nxt = w_down_sat;
                    w_state_nxt = (w_down_sat == '0) ? ST_IDLE : ST_BRAKE;
                end
            end
            ST_BRAKE: begin
                w_speed_nxt = w_down_sat;
                if (w_down_sat == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_speed_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_speed     = r_speed;
    assign o_dir       = r_dir;
    assign o_speed_nxt = w_speed_nxt;
    assign o_dir_nxt   = w_dir_nxt;
    assign o_state     = r_state;

endmodule
`default_nettype wire

// File: rtl/bat_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bat_motion_ctrl
//  Description : Horizontal bat motion with acceleration, cruise and braking.
//                Position is kept in signed fixed point and clamped to the
//                playfield; the bat width follows the length code.
//  Ports       : clk, resetN     - clock, asynchronous active-low reset
//                startOfFrame    - one-cycle pulse per video frame
//                right, left     - movement requests
//                collision       - ball/bat hit; freezes the frame update
//                length          - bat length code (bits [2:1] scale width)
//                topLeftX        - integer pixel column of the bat
//                batWidth        - bat width in pixels
//                moving          - speed FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module bat_motion_ctrl
    import bat_pkg::*;
#(
    parameter int INITIAL_X   = 285,
    parameter int FRAC_BITS   = FRAC_BITS_DEF,
    parameter int MIN_SPEED   = 64,
    parameter int MAX_SPEED   = 256,
    parameter int ACCEL       = 32,
    parameter int FRAME_MAX_X = 639,
    parameter int BASE_WIDTH  = 27,
    parameter int LEFT_LIMIT  = 0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        right,
    input  logic        left,
    input  logic        collision,
    input  logic [2:0]  length,
    output logic [10:0] topLeftX,
    output logic [10:0] batWidth,
    output logic        moving
);

    localparam logic signed [31:0] c_init_fx = 32'(INITIAL_X)  <<< FRAC_BITS;
    localparam logic signed [31:0] c_min_fx  = 32'(LEFT_LIMIT) <<< FRAC_BITS;

    logic signed [31:0] r_pos;
    logic signed [31:0] w_step;
    logic signed [31:0] w_pos_sum;
    logic signed [31:0] w_pos_nxt;
    logic signed [31:0] w_max_fx;
    logic signed [31:0] w_width_s;
    logic signed [31:0] w_pos_int;
    logic [10:0]        w_width;
    logic [SPEED_W-1:0] w_speed;
    logic [SPEED_W-1:0] w_speed_nxt;
    logic               w_dir;
    logic               w_dir_nxt;
    logic               w_advance;
    logic               w_clamp;
    bat_state_t         w_state;
    logic               w_unused;

    // A collision in the frame cycle freezes position, speed and state.
    assign w_advance = startOfFrame & ~collision;

    bat_speed_ramp #(
        .MIN_SPEED (MIN_SPEED),
        .MAX_SPEED (MAX_SPEED),
        .ACCEL     (ACCEL)
    ) u_ramp (
        .clk         (clk),
        .resetN      (resetN),
        .i_advance   (w_advance),
        .i_clamp     (w_clamp),
        .i_right     (right),
        .i_left      (left),
        .o_speed     (w_speed),
        .o_dir       (w_dir),
        .o_speed_nxt (w_speed_nxt),
        .o_dir_nxt   (w_dir_nxt),
        .o_state     (w_state)
    );

    assign w_width   = 11'(BASE_WIDTH) << length[2:1];
    assign w_width_s = {21'b0, w_width};
    assign w_max_fx  = (32'(FRAME_MAX_X) - w_width_s) <<< FRAC_BITS;

    // Move by the speed being loaded this frame, not the previous one.
    assign w_step    = {{(32-SPEED_W){1'b0}}, w_speed_nxt};
    assign w_pos_sum = w_dir_nxt ? (r_pos + w_step) : (r_pos - w_step);

    // The clamp also runs while idle, so a bat that grew past the right edge
    // is pulled back on the next frame.
    always_comb begin
        w_pos_nxt = w_pos_sum;
        w_clamp   = 1'b0;
        if (w_pos_sum > w_max_fx) begin
            w_pos_nxt = w_max_fx;
            w_clamp   = 1'b1;
        end else if (w_pos_sum < c_min_fx) begin
            w_pos_nxt = c_min_fx;
            w_clamp   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pos <= c_init_fx;
        end else if (w_advance) begin
            r_pos <= w_pos_nxt;
        end
    end

    assign w_pos_int = r_pos >>> FRAC_BITS;
    assign topLeftX  = w_pos_int[10:0];
    assign batWidth  = w_width;
    assign moving    = (w_state != ST_IDLE);

    // Bits not needed by any output, gathered to document that on purpose.
    assign w_unused = length[0] ^ (|w_pos_int[31:11]) ^ w_dir ^ (|w_speed);

endmodule
`default_nettype wire

// File: tb/tb_bat_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bat_motion_ctrl
//  Description : Directed self-checking bench for bat_motion_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bat_motion_ctrl;
    import bat_pkg::*;

    logic        clk          = 1'b0;
    logic        resetN       = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        right        = 1'b0;
    logic        left         = 1'b0;
    logic        collision    = 1'b0;
    logic [2:0]  length       = 3'd0;
    logic [10:0] topLeftX;
    logic [10:0] batWidth;
    logic        moving;

    int n_cmp = 0;
    int n_err = 0;

    int up_spd[7]  = '{64, 96, 128, 160, 192, 224, 256};
    int up_pos[7]  = '{18304, 18400, 18528, 18688, 18880, 19104, 19360};
    int up_x[7]    = '{286, 287, 289, 292, 295, 298, 302};
    int rel_spd[8] = '{224, 192, 160, 128, 96, 64, 32, 0};
    int rel_x[8]   = '{314, 317, 319, 321, 323, 324, 324, 324};

    bat_motion_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .right        (right),
        .left         (left),
        .collision    (collision),
        .length       (length),
        .topLeftX     (topLeftX),
        .batWidth     (batWidth),
        .moving       (moving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: pulse startOfFrame for one cycle, return at a falling edge.
    task automatic frame();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_x", 32'(topLeftX), 285);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_width", 32'(batWidth), 27);
        @(negedge clk);
        resetN = 1'b1;

        // Acceleration to cruise
        right = 1'b1;
        for (int i = 0; i < 7; i++) begin
            frame();
            chk($sformatf("up_spd%0d", i), 32'(dut.u_ramp.r_speed), up_spd[i]);
            chk($sformatf("up_pos%0d", i), dut.r_pos, up_pos[i]);
            chk($sformatf("up_x%0d", i), 32'(topLeftX), up_x[i]);
        end
        chk("cruise_state", 32'(dut.u_ramp.r_state), 32'(ST_CRUISE));
        frame();
        chk("cruise_x1", 32'(topLeftX), 306);
        frame();
        chk("cruise_x2", 32'(topLeftX), 310);
        chk("cruise_spd", 32'(dut.u_ramp.r_speed), 256);

        // Release: brake to a stop
        right = 1'b0;
        for (int i = 0; i < 8; i++) begin
            frame();
            chk($sformatf("rel_spd%0d", i), 32'(dut.u_ramp.r_speed), rel_spd[i]);
            chk($sformatf("rel_x%0d", i), 32'(topLeftX), rel_x[i]);
        end
        chk("rel_moving", 32'(moving), 0);
        chk("rel_pos", dut.r_pos, 20768);

        // Reverse request while cruising right
        right = 1'b1;
        for (int i = 0; i < 7; i++) frame();
        chk("rev_cruise", 32'(dut.u_ramp.r_state), 32'(ST_CRUISE));
        chk("rev_pos0", dut.r_pos, 21888);
        right = 1'b0;
        left  = 1'b1;
        frame();
        chk("rev_brake", 32'(dut.u_ramp.r_state), 32'(ST_BRAKE));
        for (int i = 0; i < 7; i++) frame();
        chk("rev_idle", 32'(moving), 0);
        chk("rev_pos1", dut.r_pos, 22784);
        frame();
        chk("rev_spd", 32'(dut.u_ramp.r_speed), 64);
        chk("rev_dir", 32'(dut.u_ramp.r_dir), 0);
        chk("rev_x", 32'(topLeftX), 355);
        chk("rev_moving", 32'(moving), 1);
        left = 1'b0;
        frame();
        frame();
        chk("rev_stop", 32'(moving), 0);
        chk("rev_pos2", dut.r_pos, 22688);

        // Collision
        right = 1'b1;
        frame();
        chk("col_pos0", dut.r_pos, 22752);
        collision = 1'b1;
        frame();
        collision = 1'b0;
        chk("col_pos_hold", dut.r_pos, 22752);
        chk("col_spd_hold", 32'(dut.u_ramp.r_speed), 64);
        chk("col_state_hold", 32'(dut.u_ramp.r_state), 32'(ST_ACCEL));
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        @(negedge clk);
        chk("col_between", dut.r_pos, 22752);
        frame();
        chk("col_resume_spd", 32'(dut.u_ramp.r_speed), 96);
        chk("col_resume_pos", dut.r_pos, 22848);
        right = 1'b0;
        for (int i = 0; i < 3; i++) frame();
        chk("col_stop", 32'(moving), 0);
        chk("col_x", 32'(topLeftX), 358);

        // Right edge and width growth
        right = 1'b1;
        for (int i = 0; i < 100; i++) frame();
        chk("edge_x", 32'(topLeftX), 612);
        chk("edge_pos", dut.r_pos, 39168);
        chk("edge_idle", 32'(moving), 0);
        right  = 1'b0;
        length = 3'd6;
        @(negedge clk);
        chk("grow_width", 32'(batWidth), 216);
        chk("grow_x_before", 32'(topLeftX), 612);
        frame();
        chk("grow_x", 32'(topLeftX), 423);
        chk("grow_idle", 32'(moving), 0);

        // Left edge
        left = 1'b1;
        for (int i = 0; i < 150; i++) frame();
        chk("ledge_x", 32'(topLeftX), 0);
        chk("ledge_pos", dut.r_pos, 0);
        chk("ledge_idle", 32'(moving), 0);
        left   = 1'b0;
        length = 3'd0;

        // Asynchronous reset mid-acceleration
        right = 1'b1;
        for (int i = 0; i < 3; i++) frame();
        chk("ar_pre_x", 32'(topLeftX), 4);
        chk("ar_pre_moving", 32'(moving), 1);
        #2;
        resetN = 1'b0;
        #1;
        chk("ar_x", 32'(topLeftX), 285);
        chk("ar_moving", 32'(moving), 0);
        chk("ar_spd", 32'(dut.u_ramp.r_speed), 0);
        right = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        frame();
        chk("ar_after_x", 32'(topLeftX), 285);
        chk("ar_after_spd", 32'(dut.u_ramp.r_speed), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
